artec_dma_burst_dispatch: RTL and testbench

- Sits between the per-channel AXIS ingress FIFOs and the AXI write master.
- Presents per-channel available-beat counts to the round-robin DMA channel arbiter.
- Captures the arbiter's one-cycle grant, sizes an INCR burst for the granted channel, and issues the AW command plus a matching W-mux command.
- Keeps a per-channel ring-buffer write pointer and a global outstanding-burst limit.

---
 rtl/artec_dma_burst_dispatch.sv | 216 +++++++++++++++++++++
 tb/tb_artec_dma_burst_dispatch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/artec_dma_burst_dispatch.sv
// -----------------------------------------------------------------------------
// artec_dma_burst_dispatch
// Sits between the per-channel AXIS ingress FIFOs and the AXI write master.
// It reports available beats per channel to the round-robin arbiter. It also
// captures the arbiter's one-cycle grant and sizes an INCR burst for that
// channel. The burst is kept within the FIFO level, MAX_BURST and the next 4 KB
// boundary. The block then issues the AW command together with a matching
// W-mux command. It keeps one ring write pointer per channel and limits the
// number of outstanding bursts globally.
//
// Ports
//   clk, rstn, clear     clock, async active-low reset, sync clear (same effect)
//   ch_en_i              per-channel enable; a disabled channel holds ptr=base
//   cfg_base_i/size_i    per-channel ring base / size (4 KB aligned), flat
//   level_i, pop_i       ingress FIFO level (beats) and one-beat pop pulses
//   avail_o              registered available beats per channel, to arbiter
//   grant_i/_valid_i     one-cycle arbiter grant
//   aw*_o, awready_i     AXI AW channel (INCR, fixed size)
//   wcmd_*               W-mux command: channel and beat count
//   b_done_i             one pulse per accepted B response
//   busy_o               FSM active or bursts outstanding
// -----------------------------------------------------------------------------
module artec_dma_burst_dispatch #(
  parameter int CH_NUM     = 4,
  parameter int LVL_WIDTH  = 16,
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 16,
  parameter int MAX_OUTST  = 4,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clear,
  input  logic [CH_NUM-1:0]             ch_en_i,
  input  logic [CH_NUM*ADDR_W-1:0]      cfg_base_i,
  input  logic [CH_NUM*ADDR_W-1:0]      cfg_size_i,
  input  logic [CH_NUM*LVL_WIDTH-1:0]   level_i,
  input  logic [CH_NUM-1:0]             pop_i,
  output logic [CH_NUM*LVL_WIDTH-1:0]   avail_o,
  input  logic [CH_W-1:0]               grant_i,
  input  logic                          grant_valid_i,
  output logic [ADDR_W-1:0]             awaddr_o,
  output logic [7:0]                    awlen_o,
  output logic [CH_W-1:0]               awid_o,
  output logic [2:0]                    awsize_o,
  output logic [1:0]                    awburst_o,
  output logic                          awvalid_o,
  input  logic                          awready_i,
  output logic [CH_W-1:0]               wcmd_ch_o,
  output logic [8:0]                    wcmd_len_o,
  output logic                          wcmd_valid_o,
  input  logic                          wcmd_ready_i,
  input  logic                          b_done_i,
  output logic                          busy_o
);

  localparam int OC_W  = $clog2(MAX_OUTST + 1);
  localparam int BB_SH = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t                state_q;
  logic [CH_W-1:0]       ch_q;
  logic [ADDR_W-1:0]     ptr_q  [CH_NUM];
  logic [LVL_WIDTH-1:0]  resv_q [CH_NUM];
  logic [LVL_WIDTH-1:0]  avail  [CH_NUM];
  logic [OC_W-1:0]       out_cnt_q;

  logic                  aw_hs, w_hs, outst_ok;
  logic [ADDR_W-1:0]     cur_ptr;
  logic [LVL_WIDTH-1:0]  cur_avail;
  logic [12:0]           to4k;
  logic [12:0]           lim;
  logic [8:0]            beats;

  assign awsize_o  = 3'(BB_SH);
  assign awburst_o = 2'b01;
  assign aw_hs     = awvalid_o & awready_i;
  assign w_hs      = wcmd_valid_o & wcmd_ready_i;
  assign outst_ok  = out_cnt_q < OC_W'(MAX_OUTST);
  assign busy_o    = (state_q != IDLE) || (out_cnt_q != '0);

  // Beats present in the FIFO but not yet claimed by an issued burst.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      avail[c] = (level_i[c*LVL_WIDTH +: LVL_WIDTH] > resv_q[c])
               ? level_i[c*LVL_WIDTH +: LVL_WIDTH] - resv_q[c] : '0;
    end
  end

  // Burst sizing for the latched channel: min(avail, MAX_BURST, beats to 4 KB).
  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    cur_ptr   = ptr_q[ch_q];
    cur_avail = avail[ch_q];
    to4k      = (13'd4096 - {1'b0, cur_ptr[11:0]}) >> BB_SH;
    lim       = to4k;
    if (13'(MAX_BURST) < lim) lim = 13'(MAX_BURST);
    if (cur_avail < LVL_WIDTH'(lim)) lim = 13'(cur_avail);
    beats     = 9'(lim);
  end

  // Control FSM with registered AW / W-command outputs.
  // NOTE: sequential state is written only with non-blocking assignments so all
  // flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      awaddr_o     <= '0;
      awlen_o      <= '0;
      awid_o       <= '0;
      awvalid_o    <= 1'b0;
      wcmd_ch_o    <= '0;
      wcmd_len_o   <= '0;
      wcmd_valid_o <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      awaddr_o     <= '0;
      awlen_o      <= '0;
      awid_o       <= '0;
      awvalid_o    <= 1'b0;
      wcmd_ch_o    <= '0;
      wcmd_len_o   <= '0;
      wcmd_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A grant is taken only when another burst is allowed in flight.
          if (grant_valid_i && outst_ok) begin
            ch_q    <= grant_i;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (beats == '0) begin
            state_q <= IDLE;
          end else begin
            awaddr_o     <= cur_ptr;
            awlen_o      <= 8'(beats - 9'd1);
            awid_o       <= ch_q;
            wcmd_ch_o    <= ch_q;
            wcmd_len_o   <= beats;
            awvalid_o    <= 1'b1;
            wcmd_valid_o <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (aw_hs) awvalid_o    <= 1'b0;
          if (w_hs)  wcmd_valid_o <= 1'b0;
          if ((aw_hs || !awvalid_o) && (w_hs || !wcmd_valid_o)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-channel ring pointer and reservation bookkeeping. The payload regs stay
  // stable until the next CALC, so wcmd_len_o holds the burst length at the AW
  // handshake even if the W command already completed.
  // NOTE: these arrays are small control registers and must start from a known
  // value, so they are reset; a data RAM would not be.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CH_NUM; c++) begin
        ptr_q[c]  <= '0;
        resv_q[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CH_NUM; c++) begin
        ptr_q[c]  <= '0;
        resv_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (!ch_en_i[c]) begin
          ptr_q[c] <= cfg_base_i[c*ADDR_W +: ADDR_W];
        end else if (aw_hs && awid_o == CH_W'(c)) begin
          if (ptr_q[c] + (ADDR_W'(wcmd_len_o) << BB_SH) ==
              cfg_base_i[c*ADDR_W +: ADDR_W] + cfg_size_i[c*ADDR_W +: ADDR_W])
            ptr_q[c] <= cfg_base_i[c*ADDR_W +: ADDR_W];
          else
            ptr_q[c] <= ptr_q[c] + (ADDR_W'(wcmd_len_o) << BB_SH);
        end
        resv_q[c] <= resv_q[c]
                   + ((aw_hs && awid_o == CH_W'(c)) ? LVL_WIDTH'(wcmd_len_o) : '0)
                   - LVL_WIDTH'(pop_i[c]);
      end
    end
  end

  // Outstanding-burst counter and the registered, gated avail_o.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt_q <= '0;
      avail_o   <= '0;
    end else if (clear) begin
      out_cnt_q <= '0;
      avail_o   <= '0;
    end else begin
      if (aw_hs && !b_done_i)
        out_cnt_q <= out_cnt_q + 1'b1;
      else if (!aw_hs && b_done_i && out_cnt_q != '0)
        out_cnt_q <= out_cnt_q - 1'b1;
      for (int c = 0; c < CH_NUM; c++) begin
        avail_o[c*LVL_WIDTH +: LVL_WIDTH] <=
          (state_q == IDLE && ch_en_i[c] && outst_ok) ? avail[c] : '0;
      end
    end
  end

endmodule

// File: tb/tb_artec_dma_burst_dispatch.sv
// -----------------------------------------------------------------------------
// Directed bench for artec_dma_burst_dispatch: table-driven level gating plus
// hand-written sequences for 4 KB split, ring wrap, outstanding limit, split
// handshake and mid-burst clear.
// -----------------------------------------------------------------------------
module tb_artec_dma_burst_dispatch;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clear = 1'b0;
  logic [3:0]    ch_en_i = '0;
  logic [127:0]  cfg_base_i = '0;
  logic [127:0]  cfg_size_i = '0;
  logic [63:0]   level_i = '0;
  logic [3:0]    pop_i = '0;
  logic [63:0]   avail_o;
  logic [1:0]    grant_i = '0;
  logic          grant_valid_i = 1'b0;
  logic [31:0]   awaddr_o;
  logic [7:0]    awlen_o;
  logic [1:0]    awid_o;
  logic [2:0]    awsize_o;
  logic [1:0]    awburst_o;
  logic          awvalid_o;
  logic          awready_i = 1'b0;
  logic [1:0]    wcmd_ch_o;
  logic [8:0]    wcmd_len_o;
  logic          wcmd_valid_o;
  logic          wcmd_ready_i = 1'b0;
  logic          b_done_i = 1'b0;
  logic          busy_o;

  int n_cmp = 0;
  int n_err = 0;
  int resv_m [4] = '{0, 0, 0, 0};

  artec_dma_burst_dispatch dut (
    .clk(clk), .rstn(rstn), .clear(clear), .ch_en_i(ch_en_i),
    .cfg_base_i(cfg_base_i), .cfg_size_i(cfg_size_i), .level_i(level_i),
    .pop_i(pop_i), .avail_o(avail_o), .grant_i(grant_i),
    .grant_valid_i(grant_valid_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awid_o(awid_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .wcmd_ch_o(wcmd_ch_o),
    .wcmd_len_o(wcmd_len_o), .wcmd_valid_o(wcmd_valid_o),
    .wcmd_ready_i(wcmd_ready_i), .b_done_i(b_done_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          ch;
    int          level;
    int          exp_avail;
    logic [31:0] exp_addr;
    int          exp_len;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_level(input int ch, input int val);
    level_i[ch*16 +: 16] = 16'(val);
  endtask

  // Waits (bounded) for awvalid_o; returns cycles taken after the grant cycle.
  task automatic wait_aw(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (awvalid_o) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL aw_wait: got no awvalid required awvalid within 10 cycles");
    end
  endtask

  task automatic grant(input int ch);
    grant_i       = 2'(ch);
    grant_valid_i = 1'b1;
    tick();
    grant_valid_i = 1'b0;
  endtask

  // One complete burst: level setup, avail check, grant, payload checks,
  // simultaneous handshake, optional B response.
  task automatic burst(input int ch, input int level, input int exp_avail,
                       input logic [31:0] exp_addr, input int exp_len,
                       input bit do_b, input string tag);
    bit ok;
    int cyc;
    set_level(ch, level);
    tick();
    tick();
    check({tag, "_avail"}, 64'(avail_o[ch*16 +: 16]), 64'(exp_avail));
    grant(ch);
    wait_aw(ok, cyc);
    if (ok) begin
      check({tag, "_latency"},  64'(cyc), 64'd1);
      check({tag, "_awaddr"},   64'(awaddr_o), 64'(exp_addr));
      check({tag, "_awlen"},    64'(awlen_o), 64'(exp_len));
      check({tag, "_awid"},     64'(awid_o), 64'(ch));
      check({tag, "_wcmd_ch"},  64'(wcmd_ch_o), 64'(ch));
      check({tag, "_wcmd_len"}, 64'(wcmd_len_o), 64'(exp_len + 1));
      check({tag, "_wvalid"},   64'(wcmd_valid_o), 64'd1);
      awready_i    = 1'b1;
      wcmd_ready_i = 1'b1;
      tick();
      awready_i    = 1'b0;
      wcmd_ready_i = 1'b0;
      check({tag, "_valids_drop"}, 64'({awvalid_o, wcmd_valid_o}), 64'd0);
    end
    resv_m[ch] += exp_len + 1;
    if (do_b) begin
      b_done_i = 1'b1;
      tick();
      b_done_i = 1'b0;
    end
  endtask

  vec_t tbl [3];

  initial begin
    bit ok;
    bit seen;
    int cyc;

    tbl[0] = '{ch: 0, level: 40, exp_avail: 40, exp_addr: 32'h1000, exp_len: 15};
    tbl[1] = '{ch: 0, level: 40, exp_avail: 24, exp_addr: 32'h1080, exp_len: 15};
    tbl[2] = '{ch: 0, level: 40, exp_avail: 8,  exp_addr: 32'h1100, exp_len: 7};

    cfg_base_i[0*32 +: 32] = 32'h1000; cfg_size_i[0*32 +: 32] = 32'h1000;
    cfg_base_i[1*32 +: 32] = 32'h1000; cfg_size_i[1*32 +: 32] = 32'h2000;
    cfg_base_i[2*32 +: 32] = 32'h0000; cfg_size_i[2*32 +: 32] = 32'h1000;
    cfg_base_i[3*32 +: 32] = 32'h4000; cfg_size_i[3*32 +: 32] = 32'h1000;

    #23;
    check("rst_avail",   64'(avail_o), 64'd0);
    check("rst_valids",  64'({awvalid_o, wcmd_valid_o}), 64'd0);
    check("rst_busy",    64'(busy_o), 64'd0);
    check("rst_payload", 64'({awaddr_o, awlen_o, wcmd_len_o}), 64'd0);
    rstn = 1'b1;
    tick();
    check("const_awsize",  64'(awsize_o), 64'd3);
    check("const_awburst", 64'(awburst_o), 64'd1);
    tick();           // disabled channels load their base pointer
    ch_en_i = 4'hF;
    tick();

    // Level gating table.
    for (int i = 0; i < 3; i++)
      burst(tbl[i].ch, tbl[i].level, tbl[i].exp_avail, tbl[i].exp_addr,
            tbl[i].exp_len, 1'b1, $sformatf("gate%0d", i));
    tick();
    tick();
    check("gate_resv_full", 64'(avail_o[15:0]), 64'd0);
    pop_i[0] = 1'b1;
    tick(); tick(); tick();
    pop_i[0] = 1'b0;
    resv_m[0] -= 3;
    tick();
    tick();
    check("gate_after_pops", 64'(avail_o[15:0]), 64'd3);

    // 4 KB split on ch1: walk ptr to 0x1FE0 first.
    for (int i = 0; i < 31; i++)
      burst(1, resv_m[1] + 16, 16, 32'h1000 + 32'(i * 128), 15, 1'b1, "ch1_walk");
    burst(1, resv_m[1] + 12, 12, 32'h1F80, 11, 1'b1, "ch1_walk_tail");
    burst(1, resv_m[1] + 16, 16, 32'h1FE0, 3,  1'b1, "split4k");
    burst(1, resv_m[1] + 12, 12, 32'h2000, 11, 1'b1, "after4k");

    // Ring wrap on ch2: walk ptr to 0xFC0.
    for (int i = 0; i < 31; i++)
      burst(2, resv_m[2] + 16, 16, 32'(i * 128), 15, 1'b1, "ch2_walk");
    burst(2, resv_m[2] + 8, 8, 32'h0F80, 7, 1'b1, "ch2_walk_tail");
    burst(2, resv_m[2] + 8, 8, 32'h0FC0, 7, 1'b1, "wrap_last");
    burst(2, resv_m[2] + 4, 4, 32'h0000, 3, 1'b1, "wrap_first");

    // Outstanding limit on ch3: four bursts with no B response.
    for (int i = 0; i < 4; i++)
      burst(3, resv_m[3] + 16, 16, 32'h4000 + 32'(i * 128), 15, 1'b0, "outst");
    set_level(3, resv_m[3] + 16);
    tick();
    tick();
    check("outst_avail_zero", 64'(avail_o), 64'd0);
    check("outst_busy", 64'(busy_o), 64'd1);
    grant(3);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= awvalid_o;
    end
    check("outst_grant_ignored", 64'(seen), 64'd0);
    b_done_i = 1'b1;
    tick();
    b_done_i = 1'b0;
    tick();
    check("outst_restored", 64'(avail_o[63:48]), 64'd16);
    b_done_i = 1'b1;
    tick(); tick(); tick();
    b_done_i = 1'b0;

    // Split handshake: W command completes first, AW held 3 cycles.
    tick();
    tick();
    check("split_avail", 64'(avail_o[63:48]), 64'd16);
    grant(3);
    wait_aw(ok, cyc);
    if (ok) begin
      wcmd_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("split_aw_held",   64'(awvalid_o), 64'd1);
        check("split_aw_stable", 64'({awaddr_o, awlen_o}), 64'({32'h4200, 8'd15}));
        check("split_w_done",    64'(wcmd_valid_o), 64'd0);
      end
      wcmd_ready_i = 1'b0;
      awready_i    = 1'b1;
      b_done_i     = 1'b1;
      tick();
      awready_i    = 1'b0;
      b_done_i     = 1'b0;
      check("split_aw_drop", 64'(awvalid_o), 64'd0);
      check("split_idle",    64'(busy_o), 64'd0);
    end
    resv_m[3] += 16;

    // Clear while in ISSUE.
    set_level(3, resv_m[3] + 16);
    tick();
    tick();
    grant(3);
    wait_aw(ok, cyc);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_valids", 64'({awvalid_o, wcmd_valid_o}), 64'd0);
    check("clear_busy",   64'(busy_o), 64'd0);
    check("clear_awaddr", 64'(awaddr_o), 64'd0);
    tick();
    check("clear_resv", 64'(avail_o[63:48]), 64'(resv_m[3] + 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
